// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master.
// Holds the FSM state encoding, the bit positions inside the latched mode
// field, and the width function for the SCL edge counter.
package spi_pkg;

    // FSM states
    //   IDLE  : CS high, SCL follows cpol_i, ready for a command
    //   SHIFT : 2*DATA_W SCL edges, one per half-period
    //   TAIL  : one more half-period of CS hold after the final edge
    //   HOLD  : CS low between burst words, ready for the next word
    //   GAP   : CS high for one half-period before returning to IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_TAIL  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Bit positions inside the 2-bit latched mode field {cpol, cpha}
    localparam int MODE_CPHA = 0;
    localparam int MODE_CPOL = 1;

    // The edge counter has to hold the values 0..2*data_w
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator for the SPI master.
// While en_i is high, tick_o pulses for one clk cycle every div_i+1 cycles.
// While en_i is low, the counter is preloaded with div_i. The first tick
// after en_i rises is therefore exactly div_i+1 cycles later.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   en_i         : count enable
//   div_i        : half-period minus one
//   tick_o       : one-cycle pulse at the end of each half-period
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = div_i;
        end else if (cnt_q == '0) begin
            tick_o = 1'b1;
            cnt_d  = div_i;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master supporting all four CPOL/CPHA modes.
// It transmits and receives full duplex, MSB first, and frames words with
// chip select. A word sent with last_i=0 keeps CS low so that the next word
// continues the burst.
//   clk_i, rst_i        : system clock, synchronous active-high reset
//   valid_i/ready_o     : command handshake
//   data_i, dc_i, last_i: word, D/C flag, end-of-burst flag
//   div_i               : half-period minus one (latched at burst start)
//   cpol_i, cpha_i      : SPI mode (latched at burst start)
//   rvalid_o, rdata_o   : received word, one-cycle valid pulse
//   busy_o              : FSM not idle
//   sda_o, sdi_i, scl_o : MOSI, MISO, serial clock
//   dc_o, cs_n_o        : data/command line, chip select (active low)
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              dc_i,
    input  logic              last_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              sda_o,
    input  logic              sdi_i,
    output logic              scl_o,
    output logic              dc_o,
    output logic              cs_n_o
);

    localparam int            EW        = edge_cnt_w(DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [EW-1:0]     edge_q, edge_d, edge_nxt;
    logic              last_q, last_d;
    logic              scl_q, scl_d;
    logic              sda_q, sda_d;
    logic              dc_q, dc_d;
    logic              cs_n_q, cs_n_d;
    logic              rvalid_q, rvalid_d;
    logic              tick, gen_en, sample_edge;
    logic [DIV_W-1:0]  gen_div;

    // The generator runs through SHIFT, TAIL and GAP. It preloads from div_i
    // in IDLE so that the accept edge starts a full half-period. In HOLD it
    // preloads from the burst divider.
    assign gen_en   = (state_q == ST_SHIFT) || (state_q == ST_TAIL) || (state_q == ST_GAP);
    assign gen_div  = (state_q == ST_IDLE) ? div_i : div_q;
    assign edge_nxt = edge_q + EW'(1);

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (gen_en),
        .div_i  (gen_div),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        mode_d      = mode_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        edge_d      = edge_q;
        last_d      = last_q;
        scl_d       = scl_q;
        sda_d       = sda_q;
        dc_d        = dc_q;
        cs_n_d      = cs_n_q;
        rvalid_d    = 1'b0;
        sample_edge = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                scl_d  = cpol_i;
                if (valid_i) begin
                    div_d   = div_i;
                    mode_d  = {cpol_i, cpha_i};
                    last_d  = last_i;
                    dc_d    = dc_i;
                    cs_n_d  = 1'b0;
                    edge_d  = '0;
                    // With cpha=0 the MSB is on the line before the first edge.
                    // tx is pre-shifted so that every later drive takes tx[MSB].
                    if (cpha_i) begin
                        tx_d = data_i;
                    end else begin
                        tx_d  = {data_i[DATA_W-2:0], 1'b0};
                        sda_d = data_i[DATA_W-1];
                    end
                    state_d = ST_SHIFT;
                end
            end

            ST_HOLD: begin
                scl_d = mode_q[MODE_CPOL];
                if (valid_i) begin
                    last_d = last_i;
                    dc_d   = dc_i;
                    edge_d = '0;
                    if (mode_q[MODE_CPHA]) begin
                        tx_d = data_i;
                    end else begin
                        tx_d  = {data_i[DATA_W-2:0], 1'b0};
                        sda_d = data_i[DATA_W-1];
                    end
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    scl_d  = ~scl_q;
                    edge_d = edge_nxt;
                    // Odd edges lead. cpha=0 samples on leading edges and
                    // cpha=1 samples on trailing edges.
                    sample_edge = edge_nxt[0] ^ mode_q[MODE_CPHA];
                    if (sample_edge) begin
                        rx_d = {rx_q[DATA_W-2:0], sdi_i};
                    end else if (edge_nxt != LAST_EDGE) begin
                        sda_d = tx_q[DATA_W-1];
                        tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (edge_nxt == LAST_EDGE) state_d = ST_TAIL;
                end
            end

            ST_TAIL: begin
                if (tick) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rx_q;
                    if (last_q) begin
                        cs_n_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_GAP: begin
                if (tick) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            mode_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            edge_q   <= '0;
            last_q   <= 1'b0;
            scl_q    <= 1'b0;
            sda_q    <= 1'b0;
            dc_q     <= 1'b0;
            cs_n_q   <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            edge_q   <= edge_d;
            last_q   <= last_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            dc_q     <= dc_d;
            cs_n_q   <= cs_n_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign ready_o  = ((state_q == ST_IDLE) || (state_q == ST_HOLD)) && !rst_i;
    assign busy_o   = (state_q != ST_IDLE);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign sda_o    = sda_q;
    assign scl_o    = scl_q;
    assign dc_o     = dc_q;
    assign cs_n_o   = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master. It uses a table of single-word
// transfers, an SPI slave model that drives MISO and captures MOSI, and an
// expectation queue that is popped on every rvalid_o. Hand-written sequences
// cover bursts, a held valid_i, a reset in mid-transfer, and a 16-bit
// instance running in mode 2.
module tb_spi_master;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid, dc, last, cpol, cpha, loopback, s_sdi, sdi;
    logic [DW-1:0] data;
    logic [7:0]    div;
    logic          ready, rvalid, busy, sda, scl, dc_out, cs_n;
    logic [DW-1:0] rdata;
    assign sdi = loopback ? sda : s_sdi;

    spi_master #(.DATA_W(DW), .DIV_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .data_i(data),
        .dc_i(dc), .last_i(last), .div_i(div), .cpol_i(cpol), .cpha_i(cpha),
        .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy), .sda_o(sda), .sdi_i(sdi),
        .scl_o(scl), .dc_o(dc_out), .cs_n_o(cs_n)
    );

    // 16-bit instance in mode 2 with MISO looped back from MOSI
    logic        v16, dc16, l16, rdy16, rv16, b16, sda16, scl16, dco16, cs16;
    logic [15:0] d16, rd16;
    logic [7:0]  div16;
    logic        cpol16, cpha16;

    spi_master #(.DATA_W(16), .DIV_W(8)) dut16 (
        .clk_i(clk), .rst_i(rst), .valid_i(v16), .ready_o(rdy16), .data_i(d16),
        .dc_i(dc16), .last_i(l16), .div_i(div16), .cpol_i(cpol16), .cpha_i(cpha16),
        .rvalid_o(rv16), .rdata_o(rd16), .busy_o(b16), .sda_o(sda16), .sdi_i(sda16),
        .scl_o(scl16), .dc_o(dco16), .cs_n_o(cs16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic [DW-1:0] mosi;
        logic          dc;
        logic          last;
        int            lat;
    } exp_t;
    typedef struct {
        logic [DW-1:0] word;
        logic          last;
    } slv_t;
    typedef struct {
        logic [15:0] d;
        logic        dc;
    } e16_t;

    exp_t exp_q[$];
    slv_t slv_q[$];
    int   acc_q[$];
    e16_t q16[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and scoreboard, evaluated away from the active edge
    logic          s_cpol = 1'b0, s_cpha = 1'b0, s_last = 1'b1, s_dc = 1'b0;
    logic [DW-1:0] s_tx = '0, s_rx = '0;
    int            s_cnt = 0, s_edges = 0, cs_rises = 0, n_rv = 0, n16 = 0;
    logic          csn_prev = 1'b1, scl_prev = 1'b0, cs_check = 1'b0;

    always @(negedge clk) begin : mon
        slv_t w;
        exp_t e;
        int   a;
        logic lead;
        if (cs_check) begin
            check("cs_high_after_last", cs_n, 1'b1);
            cs_check = 1'b0;
        end
        if (rvalid) begin
            n_rv++;
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                a = (acc_q.size() > 0) ? acc_q.pop_front() : 0;
                check("rdata", rdata, e.rdata);
                check("mosi_word", s_rx, e.mosi);
                check("dc_o", s_dc, e.dc);
                check("latency", cyc - a, e.lat);
                check("scl_edges", s_edges, 2 * DW);
                cs_check = e.last;
            end
            s_edges = 0;
        end
        if (!csn_prev && cs_n) cs_rises++;
        if (csn_prev && !cs_n) begin
            w.word = '0; w.last = 1'b1;
            if (slv_q.size() > 0) w = slv_q.pop_front();
            s_last  = w.last;
            s_edges = 0;
            if (s_cpha) begin
                s_tx = w.word; s_cnt = 0;
            end else begin
                s_sdi = w.word[DW-1]; s_tx = w.word << 1; s_cnt = 1;
            end
        end else if (!cs_n && (scl !== scl_prev)) begin
            s_edges++;
            lead = (scl !== s_cpol);
            if (lead ^ s_cpha) begin
                s_rx = {s_rx[DW-2:0], sda};
                s_dc = dc_out;
            end else if (!s_cpha) begin
                if (s_cnt == DW) begin
                    if (!s_last && slv_q.size() > 0) begin
                        w = slv_q.pop_front();
                        s_last = w.last;
                        s_sdi = w.word[DW-1]; s_tx = w.word << 1; s_cnt = 1;
                    end
                end else begin
                    s_sdi = s_tx[DW-1]; s_tx = s_tx << 1; s_cnt++;
                end
            end else begin
                if (s_cnt == DW) begin
                    w.word = '0; w.last = 1'b1;
                    if (slv_q.size() > 0) w = slv_q.pop_front();
                    s_last = w.last; s_tx = w.word; s_cnt = 0;
                end
                s_sdi = s_tx[DW-1]; s_tx = s_tx << 1; s_cnt++;
            end
        end
        csn_prev = cs_n;
        scl_prev = scl;
    end

    always @(negedge clk) begin : mon16
        e16_t e;
        if (rv16) begin
            n16++;
            if (q16.size() == 0) begin
                check("rvalid16_unexpected", 1, 0);
            end else begin
                e = q16.pop_front();
                check("rdata16", rd16, e.d);
                check("dc16", dco16, e.dc);
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] sw, input logic [DW-1:0] er,
                        input logic dcv, input logic lv, input logic cp, input logic ch,
                        input logic [7:0] dv, input int lat);
        slv_t s;
        exp_t e;
        int   t;
        @(negedge clk);
        s.word = sw; s.last = lv;
        slv_q.push_back(s);
        e.rdata = er; e.mosi = d; e.dc = dcv; e.last = lv; e.lat = lat;
        exp_q.push_back(e);
        data = d; dc = dcv; last = lv; cpol = cp; cpha = ch; div = dv; valid = 1'b1;
        t = 0;
        while (!ready && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", ready, 1'b1);
        if (cs_n) begin
            s_cpol = cp; s_cpha = ch;
        end
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_in_time", (exp_q.size() == 0) && !busy, 1'b1);
    endtask

    task automatic send16(input logic [15:0] d, input logic dcv, input logic lv);
        e16_t e;
        int   t;
        @(negedge clk);
        e.d = d; e.dc = dcv;
        q16.push_back(e);
        d16 = d; dc16 = dcv; l16 = lv; v16 = 1'b1;
        t = 0;
        while (!rdy16 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("accept16_ready", rdy16, 1'b1);
        @(posedge clk);
        #1 v16 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data, slv, er;
        logic       dc, cpol, cpha, loopb;
        logic [7:0] div;
        int         lat;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt[7];
        int   t, e, acc, viol, rv0, cs0;
        logic sp;
        exp_t ex;
        slv_t sv;

        //          data   slave  rdata  dc cpol cpha loop div     latency
        vt[0] = '{8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   17};
        vt[1] = '{8'h5A, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3,   68};
        vt[2] = '{8'hC3, 8'h96, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2,   51};
        vt[3] = '{8'h0F, 8'hF0, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1,   34};
        vt[4] = '{8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   17};
        vt[5] = '{8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   17};
        vt[6] = '{8'h81, 8'h7E, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 4352};

        rst = 1'b1; valid = 1'b0; data = '0; dc = 1'b0; last = 1'b0; cpol = 1'b0;
        cpha = 1'b0; div = '0; loopback = 1'b0; s_sdi = 1'b0;
        v16 = 1'b0; d16 = '0; dc16 = 1'b0; l16 = 1'b0; div16 = 8'd0;
        cpol16 = 1'b1; cpha16 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_scl", scl, 1'b0);
        check("rst_sda", sda, 1'b0);
        check("rst_dc", dc_out, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1'b1);

        // Single-word transfers from the vector table
        foreach (vt[i]) begin
            loopback = vt[i].loopb; cpol = vt[i].cpol; cpha = vt[i].cpha;
            repeat (2) @(negedge clk);
            check("scl_idle_level", scl, vt[i].cpol);
            send(vt[i].data, vt[i].slv, vt[i].er, vt[i].dc, 1'b1, vt[i].cpol, vt[i].cpha,
                 vt[i].div, vt[i].lat);
            wait_done(20000);
        end

        // Three-word burst; the divider and CPOL changes on word 2 must not take effect
        loopback = 1'b0;
        cs0 = cs_rises; rv0 = n_rv;
        send(8'h11, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 34);
        send(8'h22, 8'h42, 8'h42, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 34);
        send(8'h33, 8'h24, 8'h24, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 34);
        wait_done(2000);
        check("burst_cs_rises", cs_rises - cs0, 1);
        check("burst_rvalids", n_rv - rv0, 3);

        // Hold valid_i high: exactly two accepts, and ready stays low while busy
        @(negedge clk);
        rv0 = n_rv; acc = 0; viol = 0; t = 0;
        for (int k = 0; k < 2; k++) begin
            sv.word = (k == 0) ? 8'h5D : 8'hE2; sv.last = 1'b1;
            slv_q.push_back(sv);
            ex.rdata = sv.word; ex.mosi = 8'h6B; ex.dc = 1'b1; ex.last = 1'b1; ex.lat = 34;
            exp_q.push_back(ex);
        end
        data = 8'h6B; dc = 1'b1; last = 1'b1; cpol = 1'b0; cpha = 1'b0; div = 8'd1;
        s_cpol = 1'b0; s_cpha = 1'b0;
        valid = 1'b1;
        while (acc < 2 && t < 500) begin
            if (busy && ready) viol++;
            if (ready) begin
                acc++;
                acc_q.push_back(cyc + 1);
            end
            @(negedge clk);
            t++;
        end
        valid = 1'b0;
        while (busy && t < 1000) begin
            if (ready) viol++;
            @(negedge clk);
            t++;
        end
        wait_done(500);
        check("ready_low_while_busy", viol, 0);
        check("held_valid_rvalids", n_rv - rv0, 2);

        // Reset at the fifth SCL edge aborts the transfer with no rvalid
        rv0 = n_rv;
        send(8'h5C, 8'hA3, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 34);
        t = 0; e = 0; sp = scl;
        while (e < 5 && t < 200) begin
            @(negedge clk);
            if (scl !== sp) e++;
            sp = scl;
            t++;
        end
        check("reached_edge5", e, 5);
        rst = 1'b1;
        exp_q.delete(); acc_q.delete(); slv_q.delete();
        @(posedge clk);
        #1;
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ready_in_rst", ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("abort_no_rvalid", n_rv - rv0, 0);
        send(8'h96, 8'h69, 8'h69, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 34);
        wait_done(500);
        check("after_abort_rvalids", n_rv - rv0, 1);

        // 16-bit instance in mode 2: dc follows each word, and loopback proves MSB-first order
        @(negedge clk);
        check("scl16_idle", scl16, 1'b1);
        send16(16'h2A00, 1'b0, 1'b0);
        send16(16'hBEEF, 1'b1, 1'b1);
        t = 0;
        while ((n16 < 2 || b16) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("rvalids16", n16, 2);
        check("cs16_released", cs16, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
